// File: rtl/sfq_jtl_array.sv
// sfq_jtl_array: CHANNELS toggle-encoded SFQ lines, each delayed DELAY cycles, with enable, separation check and counters
// clk, rst      : rising-edge clock, synchronous active-high reset
// in, en        : toggle-encoded input pulses and per-channel accept enable
// viol_clr      : clears every sticky violation flag (a same-edge violation still sets its flag)
// out, viol     : toggle-encoded delayed pulses and sticky separation-violation flags
// pulse_cnt     : per-channel emitted-pulse count, channel i at [i*CNT_W +: CNT_W]
module sfq_jtl_array #(
   parameter int CHANNELS = 4,
   parameter int DELAY    = 4,
   parameter int MIN_SEP  = 2,
   parameter int CNT_W    = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [CHANNELS-1:0]       in,
   input  logic [CHANNELS-1:0]       en,
   input  logic                      viol_clr,
   output logic [CHANNELS-1:0]       out,
   output logic [CHANNELS-1:0]       viol,
   output logic [CHANNELS*CNT_W-1:0] pulse_cnt
);
   // MIN_SEP of 0 or 1 collapses to a threshold of 1, which a gap reloaded with 1 always meets
   localparam int GW = MIN_SEP > 1 ? $clog2(MIN_SEP + 1) : 1;
   localparam logic [GW-1:0] SEP = GW'(MIN_SEP > 1 ? MIN_SEP : 1);
   logic [CHANNELS-1:0] in_q, det, acc, bad;
   assign det = in ^ in_q;
   always_ff @(posedge clk) begin
      in_q <= in;
      viol <= rst ? '0 : (viol_clr ? bad : viol | bad);
   end
   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [GW-1:0]    gap;
      logic [DELAY-1:0] dl;
      logic             o;
      logic [CNT_W-1:0] c;
      logic             ok;
      assign ok     = gap >= SEP;
      assign acc[i] = det[i] & en[i] & ok;
      assign bad[i] = det[i] & en[i] & ~ok;
      always_ff @(posedge clk) begin
         if (rst) begin
            gap <= SEP;
            dl  <= '0;
            o   <= 1'b0;
            c   <= '0;
         end else begin
            gap <= acc[i] ? GW'(1) : (ok ? gap : gap + 1'b1);
            dl  <= DELAY'({dl, acc[i]});
            o   <= o ^ dl[DELAY-1];
            c   <= c + CNT_W'(dl[DELAY-1]);
         end
      end
      assign out[i]                     = o;
      assign pulse_cnt[i*CNT_W +: CNT_W] = c;
   end
endmodule

// File: tb/tb_sfq_jtl_array.sv
// tb_sfq_jtl_array: scoreboard bench for sfq_jtl_array against a timestamp-based reference model
module tb_sfq_jtl_array;
   localparam int NCH = 4;
   localparam int DLY = 4;
   localparam int SEP = 2;
   typedef struct {int ch; int t; int c;} ev_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NCH-1:0] in = '0;
   logic [NCH-1:0] en = '1;
   logic viol_clr = 1'b0;
   logic [NCH-1:0] out, viol;
   logic [NCH*16-1:0] pulse_cnt;
   logic rst2 = 1'b1;
   logic in2 = 1'b0;
   logic en2 = 1'b1;
   logic clr2 = 1'b0;
   logic out2, viol2;
   logic [1:0] cnt2;
   int total = 0;
   int bad = 0;
   int edge_n = 0;
   bit started = 0;
   bit rst_m = 0;
   logic [NCH-1:0] p_in, viol_m, vset, last_out;
   int last_acc [NCH];
   int cnt_m [NCH];
   ev_t sbq[$];
   int wq[$];
   bit started2 = 0;
   bit rst2_m = 0;
   logic last2;
   sfq_jtl_array #(.CHANNELS(NCH), .DELAY(DLY), .MIN_SEP(SEP), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in(in), .en(en), .viol_clr(viol_clr),
      .out(out), .viol(viol), .pulse_cnt(pulse_cnt));
   sfq_jtl_array #(.CHANNELS(1), .DELAY(1), .MIN_SEP(1), .CNT_W(2)) dut_w (
      .clk(clk), .rst(rst2), .in(in2), .en(en2), .viol_clr(clr2),
      .out(out2), .viol(viol2), .pulse_cnt(cnt2));
   always #5 clk = ~clk;
   task automatic chk(input string name, input int got, input int exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0d exp=%0d", name, edge_n, got, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   // reference model: acceptance decided from the distance to the last accepted pulse
   initial forever @(posedge clk) begin
      edge_n++;
      rst_m = rst;
      if (rst) begin
         started = 1;
         p_in = in;
         viol_m = '0;
         sbq.delete();
         for (int i = 0; i < NCH; i++) begin
            last_acc[i] = -1000;
            cnt_m[i] = 0;
         end
      end else if (started) begin
         vset = '0;
         for (int i = 0; i < NCH; i++)
            if (in[i] != p_in[i] && en[i]) begin
               if (edge_n - last_acc[i] >= SEP) begin
                  ev_t e;
                  last_acc[i] = edge_n;
                  cnt_m[i] = (cnt_m[i] + 1) & 16'hffff;
                  e.ch = i;
                  e.t = edge_n + DLY;
                  e.c = cnt_m[i];
                  sbq.push_back(e);
               end else vset[i] = 1'b1;
            end
         p_in = in;
         viol_m = viol_clr ? vset : (viol_m | vset);
      end
      rst2_m = rst2;
      if (rst2) started2 = 1;
   end
   // monitor for the main instance: every out toggle must match the oldest pending event of its channel
   initial forever @(negedge clk) begin
      if (started) begin
         if (rst_m) begin
            chk("reset out", int'(out), 0);
            chk("reset viol", int'(viol), 0);
            for (int i = 0; i < NCH; i++) chk($sformatf("reset cnt%0d", i), int'(pulse_cnt[i*16 +: 16]), 0);
            last_out = '0;
         end else begin
            chk("viol", int'(viol), int'(viol_m));
            for (int i = 0; i < NCH; i++)
               if (out[i] != last_out[i]) begin
                  int idx = -1;
                  for (int k = 0; k < sbq.size(); k++)
                     if (idx < 0 && sbq[k].ch == i) idx = k;
                  if (idx < 0) chk($sformatf("spurious toggle ch%0d", i), 1, 0);
                  else begin
                     chk($sformatf("toggle edge ch%0d", i), edge_n, sbq[idx].t);
                     chk($sformatf("pulse_cnt ch%0d", i), int'(pulse_cnt[i*16 +: 16]), sbq[idx].c);
                     sbq.delete(idx);
                  end
                  last_out[i] = out[i];
               end
            for (int k = sbq.size() - 1; k >= 0; k--)
               if (sbq[k].t <= edge_n) begin
                  chk($sformatf("missed toggle ch%0d", sbq[k].ch), edge_n, sbq[k].t);
                  sbq.delete(k);
               end
         end
      end
   end
   // monitor for the wrap instance: counts must read modulo 4
   initial forever @(negedge clk) begin
      if (started2) begin
         if (rst2_m) begin
            chk("wrap reset out", int'(out2), 0);
            chk("wrap reset cnt", int'(cnt2), 0);
            last2 = 1'b0;
         end else begin
            chk("wrap viol", int'(viol2), 0);
            if (out2 != last2) begin
               if (wq.size() == 0) chk("wrap spurious toggle", 1, 0);
               else chk("wrap cnt", int'(cnt2), wq.pop_front());
               last2 = out2;
            end
         end
      end
   end
   initial begin
      cyc(3);
      rst2 = 1'b0;
      cyc(2);
      for (int k = 1; k <= 5; k++) begin
         in2 = ~in2;
         wq.push_back(k % 4);
         cyc(1);
      end
   end
   initial begin
      cyc(3);
      rst = 1'b0;
      cyc(2);
      in[0] = ~in[0];
      cyc(10);
      in[0] = ~in[0];
      cyc(10);
      in[1] = ~in[1];
      cyc(1);
      in[1] = ~in[1];
      cyc(1);
      in[1] = ~in[1];
      cyc(8);
      in[2] = ~in[2];
      cyc(1);
      in[2] = ~in[2];
      cyc(5);
      in[2] = ~in[2];
      cyc(1);
      in[2] = ~in[2];
      viol_clr = 1'b1;
      cyc(1);
      viol_clr = 1'b0;
      cyc(5);
      viol_clr = 1'b1;
      cyc(1);
      viol_clr = 1'b0;
      cyc(3);
      en = 4'b0101;
      in = ~in;
      cyc(8);
      en = '1;
      in[0] = ~in[0];
      cyc(2);
      rst = 1'b1;
      in[0] = ~in[0];
      cyc(1);
      rst = 1'b0;
      cyc(8);
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 9) < 3) in[i] = ~in[i];
            en[i] = $urandom_range(0, 99) < 85;
         end
         viol_clr = $urandom_range(0, 99) < 5;
         rst = $urandom_range(0, 199) < 2;
         cyc(1);
      end
      rst = 1'b0;
      viol_clr = 1'b0;
      cyc(DLY + 4);
      chk("pending events", sbq.size(), 0);
      chk("wrap pending", wq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
